// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier sequencer/arbiter slice.
package mult_arb_pkg;

  localparam int MULT_W          = 16;
  localparam int PROD_W          = 2 * MULT_W;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
// A lone requester always wins; on a tie the requester that was not served
// last wins. Shared by other two-client arbiters.
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Pick a winner from the current request vector and the last-served id.
  always_comb begin
    grant_valid_o = |valid_i;
    unique case (valid_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one shift-add multiplier (St/Done/Idle/Produto)
// between two requesters with round-robin fairness and a watchdog.
// Optional feature macro: MULT_ARB_ZERO_BYPASS_EN -- when defined, a request
// with a zero operand completes on the cycle after accept without starting
// the multiplier.
//
// state | meaning
// IDLE  | waiting for a request while the multiplier is idle
// START | holding mul_st until the multiplier leaves idle
// WAIT  | multiplier running; waiting for mul_done or watchdog expiry
// RESP  | one-cycle done (and err) pulse to the granted requester
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH          = MULT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 req0_ready,
  output logic                 req0_done,
  output logic                 req0_err,
  output logic [2*WIDTH-1:0]   req0_product,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req1_ready,
  output logic                 req1_done,
  output logic                 req1_err,
  output logic [2*WIDTH-1:0]   req1_product,
  output logic                 mul_st,
  output logic [WIDTH-1:0]     mul_multiplicando,
  output logic [WIDTH-1:0]     mul_multiplicador,
  input  logic                 mul_done,
  input  logic                 mul_idle,
  input  logic [2*WIDTH-1:0]   mul_produto,
  output logic                 busy
);

  localparam int PW   = 2 * WIDTH;
  // Down-counter loaded on accept; reaching zero while still in START/WAIT
  // means TIMEOUT_CYCLES cycles have elapsed since START was entered.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  arb_state_e        state_q, state_d;
  logic              last_q,  last_d;
  logic              grant_q, grant_d;
  logic              err_q,   err_d;
  logic [WIDTH-1:0]  opa_q,   opa_d;
  logic [WIDTH-1:0]  opb_q,   opb_d;
  logic [WD_W-1:0]   wd_q,    wd_d;
  logic [PW-1:0]     prod0_q, prod0_d;
  logic [PW-1:0]     prod1_q, prod1_d;

  logic              pick_valid;
  logic              pick_id;
  logic              accept;
  logic              zero_byp;
  logic              wd_tc;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;

  rr_pick2 u_pick (
    .valid_i       ({req1_valid, req0_valid}),
    .last_i        (last_q),
    .grant_valid_o (pick_valid),
    .grant_id_o    (pick_id)
  );

  assign accept = (state_q == IDLE) && mul_idle && pick_valid && !reset;
  assign sel_a  = pick_id ? req1_a : req0_a;
  assign sel_b  = pick_id ? req1_b : req0_b;
  assign wd_tc  = (wd_q == '0);

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign zero_byp = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_byp = 1'b0;
`endif

  // Next-state, operand latch, watchdog and product capture.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    err_d   = err_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    wd_d    = wd_q;
    prod0_d = prod0_q;
    prod1_d = prod1_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = pick_id;
          err_d   = 1'b0;
          wd_d    = WD_LOAD;
          if (zero_byp) begin
            // Multiplier is left untouched; the answer is known to be zero.
            state_d = RESP;
            if (pick_id) prod1_d = '0;
            else         prod0_d = '0;
          end else begin
            opa_d   = sel_a;
            opb_d   = sel_b;
            state_d = START;
          end
        end
      end
      START: begin
        // The watchdog also covers a multiplier that never leaves idle.
        if (wd_tc) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q - WD_ONE;
          if (!mul_idle) state_d = WAIT;
        end
      end
      WAIT: begin
        if (mul_done) begin
          state_d = RESP;
          if (grant_q) prod1_d = mul_produto;
          else         prod0_d = mul_produto;
        end else if (wd_tc) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q - WD_ONE;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      wd_q    <= '0;
      prod0_q <= '0;
      prod1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wd_q    <= wd_d;
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
    end
  end

  assign req0_ready        = accept && !pick_id;
  assign req1_ready        = accept &&  pick_id;
  assign req0_done         = (state_q == RESP) && !grant_q;
  assign req1_done         = (state_q == RESP) &&  grant_q;
  assign req0_err          = req0_done && err_q;
  assign req1_err          = req1_done && err_q;
  assign req0_product      = prod0_q;
  assign req1_product      = prod1_q;
  // St is dropped as soon as the multiplier reports busy.
  assign mul_st            = (state_q == START) && mul_idle;
  assign mul_multiplicando = opa_q;
  assign mul_multiplicador = opb_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: behavioural multiplier model,
// directed scenarios and a randomized phase, all checked against a
// queue-based reference of the arbitration and response rules.
module tb_mult_arbiter;

  localparam int TO_CYC = 64;

  logic        Clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req0_done, req0_err;
  logic        req1_ready, req1_done, req1_err;
  logic [31:0] req0_product, req1_product;
  logic        mul_st;
  logic [15:0] mul_multiplicando, mul_multiplicador;
  logic        mul_done, mul_idle;
  logic [31:0] mul_produto;
  logic        busy;

  always #5 Clk = ~Clk;

  mult_arbiter #(.WIDTH(16), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .Clk               (Clk),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_a            (req0_a),
    .req0_b            (req0_b),
    .req0_ready        (req0_ready),
    .req0_done         (req0_done),
    .req0_err          (req0_err),
    .req0_product      (req0_product),
    .req1_valid        (req1_valid),
    .req1_a            (req1_a),
    .req1_b            (req1_b),
    .req1_ready        (req1_ready),
    .req1_done         (req1_done),
    .req1_err          (req1_err),
    .req1_product      (req1_product),
    .mul_st            (mul_st),
    .mul_multiplicando (mul_multiplicando),
    .mul_multiplicador (mul_multiplicador),
    .mul_done          (mul_done),
    .mul_idle          (mul_idle),
    .mul_produto       (mul_produto),
    .busy              (busy)
  );

  // Behavioural shift-add multiplier: fixed latency, optional hang.
  logic        m_idle, m_done;
  int          m_cnt;
  logic [31:0] m_prod;
  int          m_lat;
  bit          m_hang;

  assign mul_idle    = m_idle;
  assign mul_done    = m_done;
  assign mul_produto = m_done ? m_prod : 32'hDEAD_BEEF;

  always @(posedge Clk) begin
    if (reset) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_prod <= 32'd0;
    end else begin
      m_done <= 1'b0;
      if (m_idle) begin
        if (mul_st) begin
          m_idle <= 1'b0;
          m_cnt  <= m_lat;
          m_prod <= 32'(mul_multiplicando) * 32'(mul_multiplicador);
        end
      end else if (!m_hang) begin
        if (m_cnt <= 1) begin
          m_done <= 1'b1;
          m_idle <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Reference state
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] op_a [2][256];
  logic [15:0] op_b [2][256];
  int          op_wr [2];
  int          op_rd [2];
  logic [31:0] ex_p   [2][256];
  bit          ex_byp [2][256];
  bit          ex_err [2][256];
  int          ex_acc [2][256];
  int          ex_wr [2];
  int          ex_rd [2];
  bit          drv_v [2];
  logic [15:0] drv_a [2];
  logic [15:0] drv_b [2];
  bit          cons  [2];
  logic [31:0] held  [2];
  int          acc_cyc [2];
  int          done_cyc [2];
  int          raise_cyc [2];
  int          last_m;
  int          mdone_cyc;
  bit          st_chk, st_exp;
  int unsigned gap_pct, wd_pct;
  bit          rand_lat;
  int          glog [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_byp(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_ARB_ZERO_BYPASS_EN
    return (a == 16'd0) || (b == 16'd0);
`else
    return (a != a) && (b != b);
`endif
  endfunction

  function automatic logic [15:0] rnd_op();
    int unsigned r;
    r = $urandom_range(7);
    if (r == 0) return 16'd0;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  function automatic bit drained();
    return (op_rd[0] == op_wr[0]) && (op_rd[1] == op_wr[1]) &&
           !drv_v[0] && !drv_v[1] &&
           (ex_rd[0] == ex_wr[0]) && (ex_rd[1] == ex_wr[1]);
  endfunction

  task automatic push_op(input int x, input logic [15:0] a, input logic [15:0] b);
    op_a[x][op_wr[x] % 256] = a;
    op_b[x][op_wr[x] % 256] = b;
    op_wr[x]++;
  endtask

  task automatic clear_model();
    for (int x = 0; x < 2; x++) begin
      drv_v[x] = 1'b0;
      cons[x]  = 1'b0;
      held[x]  = 32'd0;
      op_rd[x] = op_wr[x];
      ex_rd[x] = ex_wr[x];
    end
    last_m = 1;
    st_chk = 1'b0;
    m_hang = 1'b0;
    glog.delete();
  endtask

  task automatic observe();
    bit          rdy [2];
    bit          dn  [2];
    bit          er  [2];
    logic [31:0] pr  [2];
    logic [31:0] exp_p;
    bit          byp;
    int          k;
    rdy[0] = req0_ready; rdy[1] = req1_ready;
    dn[0]  = req0_done;  dn[1]  = req1_done;
    er[0]  = req0_err;   er[1]  = req1_err;
    pr[0]  = req0_product; pr[1] = req1_product;
    chk("rdy_excl", 64'(rdy[0] & rdy[1]), 64'd0);
    chk("rdy_busy", 64'((rdy[0] | rdy[1]) & busy), 64'd0);
    if (st_chk) begin
      chk("st_lat", 64'(mul_st), 64'(st_exp));
      st_chk = 1'b0;
    end
    if (mul_done) mdone_cyc = cyc;
    for (int x = 0; x < 2; x++) begin
      chk("rdy_valid", 64'(rdy[x] & ~drv_v[x]), 64'd0);
      if (rdy[x] && drv_v[x]) begin
        if (drv_v[0] && drv_v[1]) chk("rr_pick", 64'(x), 64'(1 - last_m));
        byp = is_byp(drv_a[x], drv_b[x]);
        k = ex_wr[x] % 256;
        ex_p[x][k]   = 32'(drv_a[x]) * 32'(drv_b[x]);
        ex_byp[x][k] = byp;
        ex_err[x][k] = m_hang && !byp;
        ex_acc[x][k] = cyc;
        ex_wr[x]++;
        acc_cyc[x] = cyc;
        glog.push_back(x);
        st_chk = 1'b1;
        st_exp = !byp;
        cons[x] = 1'b1;
      end
      if (dn[x]) begin
        chk("done_pend", 64'(ex_wr[x] - ex_rd[x]), 64'd1);
        if (ex_wr[x] - ex_rd[x] == 1) begin
          k = ex_rd[x] % 256;
          ex_rd[x]++;
          exp_p = ex_err[x][k] ? held[x] : ex_p[x][k];
          chk("product", 64'(pr[x]), 64'(exp_p));
          chk("err", 64'(er[x]), 64'(ex_err[x][k]));
          if (ex_byp[x][k])      chk("byp_lat", 64'(cyc - ex_acc[x][k]), 64'd1);
          else if (ex_err[x][k]) chk("wd_lat", 64'(cyc - ex_acc[x][k]), 64'(TO_CYC + 1));
          else                   chk("done_lat", 64'(cyc - mdone_cyc), 64'd1);
          held[x]     = exp_p;
          last_m      = x;
          done_cyc[x] = cyc;
        end
      end else begin
        chk("hold", 64'(pr[x]), 64'(held[x]));
        chk("err_nodone", 64'(er[x]), 64'd0);
      end
    end
  endtask

  task automatic decide();
    for (int x = 0; x < 2; x++) begin
      if (cons[x]) drv_v[x] = 1'b0;
      else if (drv_v[x] && wd_pct > 0 && $urandom_range(99) < wd_pct) drv_v[x] = 1'b0;
      cons[x] = 1'b0;
      if (!drv_v[x] && op_rd[x] != op_wr[x] && $urandom_range(99) >= gap_pct) begin
        drv_v[x] = 1'b1;
        drv_a[x] = op_a[x][op_rd[x] % 256];
        drv_b[x] = op_b[x][op_rd[x] % 256];
        op_rd[x]++;
        raise_cyc[x] = cyc + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    if (rand_lat) m_lat = $urandom_range(20, 17);
    reset      = 1'b0;
    req0_valid = drv_v[0];
    req0_a     = drv_a[0];
    req0_b     = drv_b[0];
    req1_valid = drv_v[1];
    req1_a     = drv_a[1];
    req1_b     = drv_b[1];
    @(negedge Clk);
    cyc++;
    observe();
    decide();
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      reset      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge Clk);
      cyc++;
    end
    clear_model();
  endtask

  task automatic run_drain(input string tag, input int max_cyc);
    int n;
    bit fin;
    n   = 0;
    fin = drained();
    while (!fin && n < max_cyc) begin
      step();
      n++;
      fin = drained();
    end
    chk(tag, 64'(fin), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] prev;
    int          w0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    for (int x = 0; x < 2; x++) begin
      drv_a[x] = '0; drv_b[x] = '0;
    end
    m_lat = 18; m_hang = 1'b0; rand_lat = 1'b0;
    gap_pct = 0; wd_pct = 0; mdone_cyc = 0;

    // Reset state
    do_reset(3);
    step();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_st",    64'(mul_st), 64'd0);
    chk("rst_rdy",   64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_done",  64'({req0_done, req1_done}), 64'd0);
    chk("rst_prod",  64'({req0_product, req1_product}), 64'd0);
    chk("rst_opa",   64'(mul_multiplicando), 64'd0);

    // Single request on req0
    push_op(0, 16'd3, 16'd5);
    decide();
    run_drain("single_drain", 100);
    chk("single_rdy_T", 64'(acc_cyc[0] - raise_cyc[0]), 64'd0);
    chk("single_prod",  64'(req0_product), 64'd15);
    chk("single_r1",    64'(req1_product), 64'd0);

    // Contention after reset: req0 first, then req1
    do_reset(2);
    push_op(0, 16'hFFFF, 16'hFFFF);
    push_op(1, 16'd7, 16'd9);
    decide();
    run_drain("ctn_drain", 200);
    chk("ctn_n",    64'(glog.size()), 64'd2);
    chk("ctn_g0",   64'(glog[0]), 64'd0);
    chk("ctn_g1",   64'(glog[1]), 64'd1);
    chk("ctn_p0",   64'(req0_product), 64'hFFFE0001);
    chk("ctn_p1",   64'(req1_product), 64'd63);
    // Solo req0, then a fresh simultaneous pair goes to req1 first
    push_op(0, 16'd2, 16'd3);
    decide();
    run_drain("solo_drain", 100);
    glog.delete();
    push_op(0, 16'd10, 16'd11);
    push_op(1, 16'd12, 16'd13);
    decide();
    run_drain("pair_drain", 200);
    chk("pair_g0", 64'(glog[0]), 64'd1);
    chk("pair_g1", 64'(glog[1]), 64'd0);

    // Busy block: req1 arrives while req0 is in WAIT
    push_op(0, 16'd300, 16'd7);
    decide();
    w0 = ex_wr[0];
    for (int i = 0; i < 10 && ex_wr[0] == w0; i++) step();
    repeat (5) step();
    chk("blk_inwait", 64'(busy), 64'd1);
    push_op(1, 16'd9, 16'd9);
    decide();
    run_drain("blk_drain", 200);
    chk("blk_acc", 64'(acc_cyc[1] - done_cyc[0]), 64'd1);
    chk("blk_p1",  64'(req1_product), 64'd81);

    // Zero operand
    push_op(0, 16'd0, 16'd1234);
    decide();
    run_drain("zero_drain", 100);
    chk("zero_prod", 64'(req0_product), 64'd0);

    // Reset in the middle of WAIT
    push_op(0, 16'd100, 16'd200);
    decide();
    w0 = ex_wr[0];
    for (int i = 0; i < 10 && ex_wr[0] == w0; i++) step();
    repeat (6) step();
    do_reset(1);
    step();
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_st",   64'(mul_st), 64'd0);
    chk("mrst_done", 64'(req0_done), 64'd0);
    push_op(0, 16'd21, 16'd22);
    decide();
    run_drain("mrst_drain", 100);
    chk("mrst_prod", 64'(req0_product), 64'd462);

    // Watchdog: multiplier never finishes
    prev   = held[0];
    m_hang = 1'b1;
    push_op(0, 16'd4, 16'd4);
    decide();
    run_drain("wd_drain", 200);
    chk("wd_prod", 64'(req0_product), 64'(prev));
    step();
    chk("wd_idle", 64'(busy), 64'd0);
    push_op(1, 16'd5, 16'd5);
    decide();
    repeat (3) step();
    chk("wd_noready", 64'(req1_ready), 64'd0);
    do_reset(2);

    // Randomized traffic
    gap_pct  = 40;
    wd_pct   = 5;
    rand_lat = 1'b1;
    for (int i = 0; i < 30; i++) begin
      push_op(0, rnd_op(), rnd_op());
      push_op(1, rnd_op(), rnd_op());
    end
    decide();
    run_drain("rand_drain", 8000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
